// File: rtl/relu_pkg.sv
// Shared ReLU helpers: forward rule, derivative mask and backward gate.
// Functions work on a wide signed word; callers sign-extend in and truncate out.
package relu_pkg;

  localparam int RELU_MAX_W = 64;

  typedef logic signed [RELU_MAX_W-1:0] relu_word_t;

  // Negative inputs clamp to zero; everything else passes through untouched.
  function automatic relu_word_t relu_f(input relu_word_t x);
    return x[RELU_MAX_W-1] ? '0 : x;
  endfunction

  // Strictly positive only: the derivative at zero is defined as 0.
  function automatic logic relu_mask_f(input relu_word_t x);
    return !x[RELU_MAX_W-1] && (x != '0);
  endfunction

  function automatic relu_word_t relu_grad_f(input relu_word_t g, input logic m);
    return m ? g : '0;
  endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// 1-bit circular FIFO holding ReLU derivative masks between forward and backward passes.
// Pointers wrap modulo N, so N need not be a power of two.
module relu_mask_fifo #(
  parameter  int N  = 64,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(N);

  logic          mem [N];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(N));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign dout    = mem[rd_ptr];

  // NOTE: mask storage carries no reset; count and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/relu_backprop.sv
// Streaming ReLU with mask recording on the forward channel and mask-gated
// gradients on the backward channel; each channel has one output register.
module relu_backprop
  import relu_pkg::*;
#(
  parameter  int DEP = 16,
  parameter  int N   = 64,
  localparam int CW  = $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  fwd_valid,
  input  logic signed [DEP-1:0] fwd_x,
  output logic                  fwd_ready,
  output logic                  fwd_y_valid,
  output logic signed [DEP-1:0] fwd_y,
  input  logic                  fwd_y_ready,
  input  logic                  bwd_valid,
  input  logic signed [DEP-1:0] bwd_g,
  output logic                  bwd_ready,
  output logic                  bwd_d_valid,
  output logic signed [DEP-1:0] bwd_d,
  input  logic                  bwd_d_ready,
  output logic [CW-1:0]         mask_count
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head_mask;
  logic                  fwd_acc;
  logic                  bwd_acc;
  logic                  fwd_mask;
  logic signed [DEP-1:0] fwd_y_next;
  logic signed [DEP-1:0] bwd_d_next;

  // Readiness looks only at current state, so a full FIFO blocks a push even
  // when a pop frees a slot in the same cycle.
  assign fwd_ready = rst_n & ~clr & ~fifo_full  & (~fwd_y_valid | fwd_y_ready);
  assign bwd_ready = rst_n & ~clr & ~fifo_empty & (~bwd_d_valid | bwd_d_ready);
  assign fwd_acc   = fwd_valid & fwd_ready;
  assign bwd_acc   = bwd_valid & bwd_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fwd_y_next = '0;
    bwd_d_next = '0;
    fwd_mask   = 1'b0;
    fwd_y_next = DEP'(relu_f(relu_word_t'(fwd_x)));
    fwd_mask   = relu_mask_f(relu_word_t'(fwd_x));
    bwd_d_next = DEP'(relu_grad_f(relu_word_t'(bwd_g), head_mask));
  end

  relu_mask_fifo #(.N(N)) u_mask_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (fwd_acc),
    .din   (fwd_mask),
    .pop   (bwd_acc),
    .dout  (head_mask),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (mask_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_y_valid <= 1'b0;
      fwd_y       <= '0;
    end else if (clr) begin
      fwd_y_valid <= 1'b0;
      fwd_y       <= '0;
    end else if (fwd_acc) begin
      fwd_y_valid <= 1'b1;
      fwd_y       <= fwd_y_next;
    end else if (fwd_y_ready) begin
      fwd_y_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bwd_d_valid <= 1'b0;
      bwd_d       <= '0;
    end else if (clr) begin
      bwd_d_valid <= 1'b0;
      bwd_d       <= '0;
    end else if (bwd_acc) begin
      bwd_d_valid <= 1'b1;
      bwd_d       <= bwd_d_next;
    end else if (bwd_d_ready) begin
      bwd_d_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_backprop.sv
// Scoreboard bench for relu_backprop (DEP=8, N=4): driver queues hand-computed
// results on accept, a negedge monitor checks them as outputs transfer.
module tb_relu_backprop;

  localparam int DEP = 8;
  localparam int N   = 4;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst_n, clr;
  logic           fwd_valid, fwd_ready, fwd_y_valid, fwd_y_ready;
  logic           bwd_valid, bwd_ready, bwd_d_valid, bwd_d_ready;
  logic [DEP-1:0] fwd_x, fwd_y, bwd_g, bwd_d;
  logic [CW-1:0]  mask_count;

  int checks = 0;
  int errors = 0;
  logic [DEP-1:0] fwd_q [$];
  logic [DEP-1:0] bwd_q [$];

  always #5 clk = ~clk;

  relu_backprop #(.DEP(DEP), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .fwd_valid   (fwd_valid),
    .fwd_x       (fwd_x),
    .fwd_ready   (fwd_ready),
    .fwd_y_valid (fwd_y_valid),
    .fwd_y       (fwd_y),
    .fwd_y_ready (fwd_y_ready),
    .bwd_valid   (bwd_valid),
    .bwd_g       (bwd_g),
    .bwd_ready   (bwd_ready),
    .bwd_d_valid (bwd_d_valid),
    .bwd_d       (bwd_d),
    .bwd_d_ready (bwd_d_ready),
    .mask_count  (mask_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; expected outputs are queued only if the DUT accepts.
  task automatic cyc(input logic fv, input logic [DEP-1:0] fx, input logic [DEP-1:0] ey,
                     input logic bv, input logic [DEP-1:0] bg, input logic [DEP-1:0] ed,
                     output logic fa, output logic ba);
    fwd_valid = fv;
    fwd_x     = fx;
    bwd_valid = bv;
    bwd_g     = bg;
    @(negedge clk);
    fa = fv & fwd_ready;
    ba = bv & bwd_ready;
    if (fa) fwd_q.push_back(ey);
    if (ba) bwd_q.push_back(ed);
    @(posedge clk);
    #1;
    fwd_valid = 1'b0;
    bwd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fwd_y_valid && fwd_y_ready) begin
        if (fwd_q.size() == 0) check("fwd_unexpected_output", 32'(fwd_y_valid), 32'(0));
        else                   check("fwd_y", 32'(fwd_y), 32'(fwd_q.pop_front()));
      end
      if (bwd_d_valid && bwd_d_ready) begin
        if (bwd_q.size() == 0) check("bwd_unexpected_output", 32'(bwd_d_valid), 32'(0));
        else                   check("bwd_d", 32'(bwd_d), 32'(bwd_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic fa, ba;
    // Basic vectors: x = 5, -3, 0, 127 ; g = 10, 10, 10, -128
    logic [DEP-1:0] t1_x [4] = '{8'h05, 8'hFD, 8'h00, 8'h7F};
    logic [DEP-1:0] t1_y [4] = '{8'h05, 8'h00, 8'h00, 8'h7F};
    logic [DEP-1:0] t2_g [4] = '{8'h0A, 8'h0A, 8'h0A, 8'h80};
    logic [DEP-1:0] t2_d [4] = '{8'h0A, 8'h00, 8'h00, 8'h80};
    // Stream: x = 3,-1,0,7,-128,1,100,-50,64,2 ; g = 11,12,13,-14,15,-16,17,18,-19,-128
    logic [DEP-1:0] s_x [10] = '{8'h03, 8'hFF, 8'h00, 8'h07, 8'h80, 8'h01, 8'h64, 8'hCE, 8'h40, 8'h02};
    logic [DEP-1:0] s_y [10] = '{8'h03, 8'h00, 8'h00, 8'h07, 8'h00, 8'h01, 8'h64, 8'h00, 8'h40, 8'h02};
    logic [DEP-1:0] s_g [10] = '{8'h0B, 8'h0C, 8'h0D, 8'hF2, 8'h0F, 8'hF0, 8'h11, 8'h12, 8'hED, 8'h80};
    logic [DEP-1:0] s_d [10] = '{8'h0B, 8'h00, 8'h00, 8'hF2, 8'h00, 8'hF0, 8'h11, 8'h00, 8'hED, 8'h80};

    rst_n = 1'b0; clr = 1'b0;
    fwd_valid = 1'b0; fwd_x = '0; fwd_y_ready = 1'b1;
    bwd_valid = 1'b0; bwd_g = '0; bwd_d_ready = 1'b1;
    #2;
    check("rst_fwd_ready", 32'(fwd_ready), 32'(0));
    check("rst_fwd_y_valid", 32'(fwd_y_valid), 32'(0));
    check("rst_fwd_y", 32'(fwd_y), 32'(0));
    check("rst_bwd_d_valid", 32'(bwd_d_valid), 32'(0));
    check("rst_bwd_d", 32'(bwd_d), 32'(0));
    check("rst_mask_count", 32'(mask_count), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_fwd_ready", 32'(fwd_ready), 32'(1));
    check("post_rst_bwd_ready", 32'(bwd_ready), 32'(0));

    // Fill the FIFO to depth N.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, t1_x[i], t1_y[i], 1'b0, '0, '0, fa, ba);
      check("fill_accept", 32'(fa), 32'(1));
    end
    check("fill_count", 32'(mask_count), 32'(4));
    check("full_fwd_ready", 32'(fwd_ready), 32'(0));

    // Drain with gradients.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, '0, 1'b1, t2_g[i], t2_d[i], fa, ba);
      check("drain_accept", 32'(ba), 32'(1));
    end
    check("drain_count", 32'(mask_count), 32'(0));
    check("empty_bwd_ready", 32'(bwd_ready), 32'(0));

    // Gradients offered to an empty FIFO are never accepted.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, '0, 1'b1, 8'h33, 8'h00, fa, ba);
      check("empty_no_accept", 32'(ba), 32'(0));
      check("empty_bwd_d_valid", 32'(bwd_d_valid), 32'(0));
    end

    // Interleaved stream, backward one cycle behind forward, wrapping the pointers.
    for (int k = 0; k <= 10; k++) begin
      int  j;
      logic fv, bv;
      j  = (k > 0) ? k - 1 : 0;
      fv = (k < 10);
      bv = (k > 0);
      cyc(fv, fv ? s_x[k] : 8'h00, fv ? s_y[k] : 8'h00, bv, s_g[j], s_d[j], fa, ba);
      check("stream_fwd_accept", 32'(fa), 32'(fv));
      check("stream_bwd_accept", 32'(ba), 32'(bv));
      check("stream_count", 32'(mask_count), (k < 10) ? 32'd1 : 32'd0);
    end

    // Forward backpressure: output held, no accept, no push.
    fwd_y_ready = 1'b0;
    cyc(1'b1, 8'h09, 8'h09, 1'b0, '0, '0, fa, ba);
    check("stall_first_accept", 32'(fa), 32'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h14, 8'h14, 1'b0, '0, '0, fa, ba);
      check("stall_no_accept", 32'(fa), 32'(0));
      check("stall_fwd_y", 32'(fwd_y), 32'(9));
      check("stall_fwd_y_valid", 32'(fwd_y_valid), 32'(1));
      check("stall_count", 32'(mask_count), 32'(1));
    end
    fwd_y_ready = 1'b1;
    cyc(1'b1, 8'h14, 8'h14, 1'b0, '0, '0, fa, ba);
    check("release_accept", 32'(fa), 32'(1));
    check("release_count", 32'(mask_count), 32'(2));

    // Build count 3 with both output registers loaded, then flush.
    cyc(1'b1, 8'hFB, 8'h00, 1'b0, '0, '0, fa, ba);
    check("pre_clr_accept", 32'(fa), 32'(1));
    cyc(1'b1, 8'h06, 8'h06, 1'b1, 8'hF9, 8'hF9, fa, ba);
    check("pre_clr_pushpop_count", 32'(mask_count), 32'(3));
    check("pre_clr_bwd_accept", 32'(ba), 32'(1));
    clr = 1'b1;
    cyc(1'b1, 8'h01, 8'h01, 1'b1, 8'h01, 8'h01, fa, ba);
    clr = 1'b0;
    check("clr_fwd_blocked", 32'(fa), 32'(0));
    check("clr_bwd_blocked", 32'(ba), 32'(0));
    check("clr_count", 32'(mask_count), 32'(0));
    check("clr_fwd_y_valid", 32'(fwd_y_valid), 32'(0));
    check("clr_bwd_d_valid", 32'(bwd_d_valid), 32'(0));

    // After flush the FIFO restarts cleanly: -128 gives mask 0.
    cyc(1'b1, 8'h80, 8'h00, 1'b0, '0, '0, fa, ba);
    check("post_clr_fwd_accept", 32'(fa), 32'(1));
    cyc(1'b0, '0, '0, 1'b1, 8'h05, 8'h00, fa, ba);
    check("post_clr_bwd_accept", 32'(ba), 32'(1));
    cyc(1'b0, '0, '0, 1'b0, '0, '0, fa, ba);

    // Asynchronous reset mid-stream.
    cyc(1'b1, 8'h04, 8'h04, 1'b0, '0, '0, fa, ba);
    cyc(1'b1, 8'hFE, 8'h00, 1'b0, '0, '0, fa, ba);
    check("mid_pre_rst_count", 32'(mask_count), 32'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_fwd_y_valid", 32'(fwd_y_valid), 32'(0));
    check("mid_rst_fwd_y", 32'(fwd_y), 32'(0));
    check("mid_rst_bwd_d_valid", 32'(bwd_d_valid), 32'(0));
    check("mid_rst_bwd_d", 32'(bwd_d), 32'(0));
    check("mid_rst_count", 32'(mask_count), 32'(0));
    check("mid_rst_fwd_ready", 32'(fwd_ready), 32'(0));
    fwd_q.delete();
    bwd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_post_rst_fwd_ready", 32'(fwd_ready), 32'(1));
    check("mid_post_rst_bwd_ready", 32'(bwd_ready), 32'(0));

    repeat (2) @(posedge clk);
    check("fwd_queue_drained", 32'(fwd_q.size()), 32'(0));
    check("bwd_queue_drained", 32'(bwd_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
